// File: rtl/seg7_time_scanner_pkg.sv
// Shared display definitions for the 7-segment display blocks.
//   - Segment vectors are active-low, bit order {g,f,e,d,c,b,a} (bit 6 = g, bit 0 = a).
//   - Glyph constants: dash, blank, page letters H / n / S.
//   - Page encoding: PAGE_HH / PAGE_MM / PAGE_SS (2 bits).
// No ports; import with seg7_time_scanner_pkg::*.
package seg7_time_scanner_pkg;

  // Bit-order reference for a segment vector.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg7_bits_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_H   = 7'h09;
  localparam logic [6:0] GLYPH_N   = 7'h2B;
  localparam logic [6:0] GLYPH_S   = 7'h12;

  typedef logic [1:0] page_t;
  localparam page_t PAGE_HH = 2'd0;
  localparam page_t PAGE_MM = 2'd1;
  localparam page_t PAGE_SS = 2'd2;

  function automatic logic [6:0] page_glyph(input page_t pg);
    case (pg)
      PAGE_HH: page_glyph = GLYPH_H;
      PAGE_MM: page_glyph = GLYPH_N;
      PAGE_SS: page_glyph = GLYPH_S;
      default: page_glyph = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_time_scanner_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low 7-segment decoder.
// Ports:
//   bcd  in  4  BCD digit; values above 9 are shown as '-'
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_time_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_time_scanner.sv
// seg7_time_scanner: scans BCD hh/mm/ss + pm onto a 3-digit common-anode display.
// Pages rotate H-hh, n-mm, S-ss; the page-letter digit's DP shows PM. All three
// digits of a frame come from one snapshot taken at the previous frame end.
// Ports:
//   i_clk    in   1  system clock
//   i_reset  in   1  synchronous, active-high reset
//   i_hh     in   8  hours BCD {tens,ones}
//   i_mm     in   8  minutes BCD
//   i_ss     in   8  seconds BCD
//   i_pm     in   1  1 = PM
//   i_hold   in   1  1 = freeze current page (scanning continues)
//   o_seg    out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   o_dp     out  1  decimal point, active-low, registered
//   o_an     out  3  digit enables, active-low, registered; [2] = leftmost
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero hours-tens digit.
module seg7_time_scanner
  import seg7_time_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 16667,
  parameter int DEAD_CYCLES = 16,
  parameter int PAGE_FRAMES = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  input  logic [7:0] i_ss,
  input  logic       i_pm,
  input  logic       i_hold,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [2:0] o_an
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(PAGE_FRAMES - 1);

  logic [PW-1:0] p;
  logic [1:0]    d;
  logic [FW-1:0] f;
  page_t         page;
  logic [7:0]    snap_hh, snap_mm, snap_ss;
  logic          snap_pm;

  logic          slot_end, frame_end;
  logic [7:0]    field;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_nxt;
  logic [2:0]    an_nxt;
  logic          dp_nxt;

  assign slot_end  = (p == P_LAST);
  assign frame_end = slot_end && (d == 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      p       <= '0;
      d       <= 2'd0;
      f       <= '0;
      page    <= PAGE_HH;
      snap_hh <= 8'h00;
      snap_mm <= 8'h00;
      snap_ss <= 8'h00;
      snap_pm <= 1'b0;
    end else begin
      p <= slot_end ? '0 : p + PW'(1);
      if (slot_end) d <= (d == 2'd2) ? 2'd0 : d + 2'd1;
      if (frame_end) begin
        snap_hh <= i_hh;
        snap_mm <= i_mm;
        snap_ss <= i_ss;
        snap_pm <= i_pm;
        if (f == F_LAST) begin
          f <= '0;
          if (!i_hold) page <= (page == PAGE_SS) ? PAGE_HH : page + 2'd1;
        end else begin
          f <= f + FW'(1);
        end
      end
    end
  end

  always_comb begin
    case (page)
      PAGE_HH: field = snap_hh;
      PAGE_MM: field = snap_mm;
      default: field = snap_ss;
    endcase
    nibble = (d == 2'd1) ? field[7:4] : field[3:0];
  end

  bcd_to_seg7 u_dec (
    .bcd (nibble),
    .seg (dec_seg)
  );

  // Next-output values are derived from the current p/d, so the registered
  // segments and anode always belong to the same slot.
  always_comb begin
    seg_nxt = dec_seg;
    if (d == 2'd2) seg_nxt = page_glyph(page);
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2'd1 && page == PAGE_HH && field[7:4] == 4'd0) seg_nxt = SEG_BLANK;
`endif
    case (d)
      2'd0:    an_nxt = 3'b110;
      2'd1:    an_nxt = 3'b101;
      2'd2:    an_nxt = 3'b011;
      default: an_nxt = 3'b111;
    endcase
    if (p < P_DEAD) an_nxt = 3'b111;
    dp_nxt = !((d == 2'd2) && snap_pm);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_seg <= SEG_BLANK;
      o_dp  <= 1'b1;
      o_an  <= 3'b111;
    end else begin
      o_seg <= seg_nxt;
      o_dp  <= dp_nxt;
      o_an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_time_scanner.sv
module tb_seg7_time_scanner;

  localparam int R  = 4;
  localparam int DC = 1;
  localparam int PF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] hh, mm, ss;
  logic       pm, hold;
  logic [6:0] o_seg;
  logic       o_dp;
  logic [2:0] o_an;

  always #5 clk = ~clk;

  seg7_time_scanner #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (DC),
    .PAGE_FRAMES (PF)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_hh    (hh),
    .i_mm    (mm),
    .i_ss    (ss),
    .i_pm    (pm),
    .i_hold  (hold),
    .o_seg   (o_seg),
    .o_dp    (o_dp),
    .o_an    (o_an)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: elapsed cycles since reset, frames completed, shown page, snapshot.
  int         t;
  int         frames;
  int         m_page;
  logic [7:0] m_hh, m_mm, m_ss;
  logic       m_pm;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [2:0] e_an;
  logic       e_rst;

  function automatic logic [6:0] digit_glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic clock_step();
    int         p_m;
    int         d_m;
    logic [7:0] fld;
    logic [3:0] nib;
    @(posedge clk);
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 3'b111; e_rst = 1'b1;
      t = 0; frames = 0; m_page = 0;
      m_hh = 8'h00; m_mm = 8'h00; m_ss = 8'h00; m_pm = 1'b0;
    end else begin
      e_rst = 1'b0;
      p_m = t % R;
      d_m = (t / R) % 3;
      fld = (m_page == 0) ? m_hh : (m_page == 1) ? m_mm : m_ss;
      e_an = 3'b111;
      if (p_m >= DC) e_an[d_m] = 1'b0;
      if (d_m == 2) begin
        e_seg = (m_page == 0) ? 7'h09 : (m_page == 1) ? 7'h2B : 7'h12;
      end else begin
        nib = (d_m == 1) ? fld[7:4] : fld[3:0];
        e_seg = digit_glyph(nib);
`ifdef LEADING_ZERO_BLANK_EN
        if (d_m == 1 && m_page == 0 && nib == 4'd0) e_seg = 7'h7F;
`endif
      end
      e_dp = !(d_m == 2 && m_pm);
      if (p_m == R - 1 && d_m == 2) begin
        m_hh = hh; m_mm = mm; m_ss = ss; m_pm = pm;
        frames++;
        if (frames % PF == 0 && !hold) m_page = (m_page + 1) % 3;
      end
      t++;
    end
    @(negedge clk);
    n_cmp++;
    assert (o_an === e_an) else begin
      n_bad++;
      $error("FAIL an t=%0d got %b expected %b", t, o_an, e_an);
    end
    if (e_an != 3'b111 || e_rst) begin
      n_cmp++;
      assert (o_seg === e_seg) else begin
        n_bad++;
        $error("FAIL seg t=%0d an=%b got %h expected %h", t, e_an, o_seg, e_seg);
      end
      n_cmp++;
      assert (o_dp === e_dp) else begin
        n_bad++;
        $error("FAIL dp t=%0d an=%b got %b expected %b", t, e_an, o_dp, e_dp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hh = 8'h00; mm = 8'h00; ss = 8'h00; pm = 1'b0; hold = 1'b0;
    repeat (3) clock_step();
    rst = 1'b0;

    // 11:47:05 PM across several frames and page changes
    hh = 8'h11; mm = 8'h47; ss = 8'h05; pm = 1'b1;
    repeat (36) clock_step();

    // hours change in the middle of a frame
    repeat (5) clock_step();
    hh = 8'h12;
    repeat (24) clock_step();

    // page hold for six frames, then release
    hold = 1'b1;
    repeat (72) clock_step();
    hold = 1'b0;
    repeat (48) clock_step();

    // leading-zero hours, invalid minutes tens, AM
    hh = 8'h09; mm = 8'hA3; pm = 1'b0;
    repeat (72) clock_step();

    // randomized inputs, hold and occasional mid-slot reset
    repeat (4000) begin
      if ($urandom_range(0, 15) == 0) begin
        hh = 8'($urandom);
        mm = 8'($urandom);
        ss = 8'($urandom);
        pm = 1'($urandom);
      end
      if ($urandom_range(0, 40) == 0) hold = ~hold;
      if ($urandom_range(0, 600) == 0) rst = 1'b1;
      clock_step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
